// File: rtl/mux_scan_nxm.sv
// Registered N-channel, M-input selector with manual select or a dwell-timed
// scan counter; every channel picks the same input index each cycle.
module mux_scan_nxm #(
  parameter  int NUM_IN = 4,
  parameter  int NUM_CH = 2,
  parameter  int WIDTH  = 1,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH*NUM_IN*WIDTH-1:0]  in_bus,
  input  logic [NUM_CH-1:0]               en_n,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            mode,
  input  logic                            hold,
  output logic [NUM_CH*WIDTH-1:0]         y,
  output logic                            y_valid,
  output logic [SEL_W-1:0]                cur_sel,
  output logic                            wrap
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [0:0] ST_MANUAL = 1'b0;
  localparam logic [0:0] ST_SCAN   = 1'b1;

  localparam logic [SEL_W:0]   NUM_IN_W   = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_IN - 1);
  localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

  logic [0:0]              state_q,    state_d;
  logic [SEL_W-1:0]        scan_sel_q, scan_sel_d;
  logic [DW_W-1:0]         dwell_q,    dwell_d;
  logic [NUM_CH*WIDTH-1:0] y_q,        y_d;
  logic                    valid_q,    valid_d;
  logic [SEL_W-1:0]        cur_sel_q,  cur_sel_d;
  logic                    wrap_q,     wrap_d;

  logic [SEL_W-1:0]        sel_eff;
  logic                    sel_ok;
  logic [NUM_CH*WIDTH-1:0] sample;

  // Select is taken from the pre-edge state, so the mode-change edge still
  // samples with the old source.
  always_comb begin
    sel_eff = (state_q == ST_MANUAL) ? sel : scan_sel_q;
    sel_ok  = ({1'b0, sel_eff} < NUM_IN_W);
    sample  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!en_n[c] && sel_ok) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (sel_eff == SEL_W'(i)) begin
            sample[c*WIDTH +: WIDTH] = in_bus[(c*NUM_IN + i)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d    = state_q;
    scan_sel_d = scan_sel_q;
    dwell_d    = dwell_q;
    y_d        = y_q;
    valid_d    = valid_q;
    cur_sel_d  = cur_sel_q;
    wrap_d     = 1'b0;

    if (!hold) begin
      y_d       = sample;
      valid_d   = sel_ok && (en_n != '1);
      cur_sel_d = sel_eff;

      case (state_q)
        ST_MANUAL: begin
          if (mode) begin
            state_d    = ST_SCAN;
            scan_sel_d = '0;
            dwell_d    = '0;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            state_d    = ST_MANUAL;
            scan_sel_d = '0;
            dwell_d    = '0;
          end else if (dwell_q == LAST_DWELL) begin
            dwell_d = '0;
            if (scan_sel_q == LAST_SEL) begin
              scan_sel_d = '0;
              wrap_d     = 1'b1;
            end else begin
              scan_sel_d = scan_sel_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: begin
          state_d    = ST_MANUAL;
          scan_sel_d = '0;
          dwell_d    = '0;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_MANUAL;
      scan_sel_q <= '0;
      dwell_q    <= '0;
      y_q        <= '0;
      valid_q    <= 1'b0;
      cur_sel_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_sel_q <= scan_sel_d;
      dwell_q    <= dwell_d;
      y_q        <= y_d;
      valid_q    <= valid_d;
      cur_sel_q  <= cur_sel_d;
      wrap_q     <= wrap_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_nxm.sv
// Scoreboard bench for mux_scan_nxm: default instance (4x2x1, DWELL=4) and a
// wide instance (5 inputs, 3 channels, 4 bits, DWELL=2).
module tb_mux_scan_nxm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic [7:0] in_bus_a;
  logic [1:0] en_n_a, sel_a, y_a, cur_sel_a;
  logic       mode_a, hold_a, y_valid_a, wrap_a;

  // Instance B: NUM_IN=5, NUM_CH=3, WIDTH=4, DWELL=2
  logic [59:0] in_bus_b;
  logic [2:0]  en_n_b, sel_b, cur_sel_b;
  logic [11:0] y_b;
  logic        mode_b, hold_b, y_valid_b, wrap_b;

  mux_scan_nxm dut_a (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus_a), .en_n(en_n_a), .sel(sel_a),
    .mode(mode_a), .hold(hold_a), .y(y_a), .y_valid(y_valid_a),
    .cur_sel(cur_sel_a), .wrap(wrap_a)
  );

  mux_scan_nxm #(.NUM_IN(5), .NUM_CH(3), .WIDTH(4), .DWELL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus_b), .en_n(en_n_b), .sel(sel_b),
    .mode(mode_b), .hold(hold_b), .y(y_b), .y_valid(y_valid_b),
    .cur_sel(cur_sel_b), .wrap(wrap_b)
  );

  typedef struct {
    int          dut;
    logic [11:0] y;
    logic        v;
    logic [2:0]  s;
    logic        w;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Packed layout for comparisons: {y[11:0], y_valid, cur_sel[2:0], wrap}
  function automatic logic [16:0] pack_a();
    return {10'b0, y_a, y_valid_a, 1'b0, cur_sel_a, wrap_a};
  endfunction

  function automatic logic [16:0] pack_b();
    return {y_b, y_valid_b, cur_sel_b, wrap_b};
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {y,v,sel,wrap}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_exp(input int dut, input logic [11:0] y, input logic v,
                          input logic [2:0] s, input logic w, input string name);
    exp_t e;
    @(posedge clk);
    e.dut = dut; e.y = y; e.v = v; e.s = s; e.w = w; e.name = name;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: one expectation per edge, compared on the following falling edge
  initial begin
    exp_t e;
    logic [16:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = (e.dut == 0) ? pack_a() : pack_b();
        check(e.name, act, {e.y, e.v, e.s, e.w});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-computed outputs: A with ch0=4'b1110, ch1=4'b0001 both enabled
  logic [1:0]  exp_a [4] = '{2'b10, 2'b01, 2'b01, 2'b01};
  // B nibbles: ch0 1..5, ch1 6..A, ch2 B,C,D,E,A; y = {ch2,ch1,ch0}
  logic [11:0] exp_b [5] = '{12'hB61, 12'hC72, 12'hD83, 12'hE94, 12'hAA5};

  initial begin
    int s;
    rst_n    = 1'b1;
    in_bus_a = '0; en_n_a = 2'b11; sel_a = '0; mode_a = 1'b0; hold_a = 1'b0;
    in_bus_b = '0; en_n_b = 3'b111; sel_b = '0; mode_b = 1'b0; hold_b = 1'b0;
    for (int k = 0; k < 14; k++) in_bus_b[k*4 +: 4] = 4'(k + 1);
    in_bus_b[14*4 +: 4] = 4'hA;

    #1 rst_n = 1'b0;
    #1;
    check("reset_a", pack_a(), 17'h0);
    check("reset_b", pack_b(), 17'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: manual sweep
    in_bus_a = 8'b0001_1110; en_n_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      tick_exp(0, {10'b0, exp_a[i]}, 1'b1, 3'(i), 1'b0, $sformatf("manual_sel%0d", i));
    end

    // 2: enables
    in_bus_a = 8'b0010_0010; sel_a = 2'd1;
    en_n_a = 2'b01; tick_exp(0, 12'h2, 1'b1, 3'd1, 1'b0, "en_ch1_only");
    en_n_a = 2'b10; tick_exp(0, 12'h1, 1'b1, 3'd1, 1'b0, "en_ch0_only");
    en_n_a = 2'b11; tick_exp(0, 12'h0, 1'b0, 3'd1, 1'b0, "en_none");

    // 3: scan entry edge still uses manual sel, then 4 edges per input
    in_bus_a = 8'b0001_1110; en_n_a = 2'b00; sel_a = 2'd0; mode_a = 1'b1;
    tick_exp(0, {10'b0, exp_a[0]}, 1'b1, 3'd0, 1'b0, "scan_entry");
    for (int k = 1; k <= 25; k++) begin
      s = ((k - 1) / 4) % 4;
      tick_exp(0, {10'b0, exp_a[s]}, 1'b1, 3'(s), k == 16, $sformatf("scan_k%0d", k));
    end

    // 4: hold at cur_sel=2, dwell_cnt=1; mode and sel wiggle while held
    hold_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mode_a = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      sel_a  = 2'(k);
      tick_exp(0, {10'b0, exp_a[2]}, 1'b1, 3'd2, 1'b0, $sformatf("hold_k%0d", k));
    end
    hold_a = 1'b0; mode_a = 1'b1; sel_a = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      s = (k <= 3) ? 2 : 3;
      tick_exp(0, {10'b0, exp_a[s]}, 1'b1, 3'(s), 1'b0, $sformatf("post_hold_k%0d", k));
    end

    // 5: asynchronous reset mid-scan while cur_sel=3
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_scan", pack_a(), 17'h0);
    #1 rst_n = 1'b1;
    tick_exp(0, {10'b0, exp_a[1]}, 1'b1, 3'd1, 1'b0, "after_reset_manual");
    for (int k = 1; k <= 8; k++) begin
      s = (k - 1) / 4;
      tick_exp(0, {10'b0, exp_a[s]}, 1'b1, 3'(s), 1'b0, $sformatf("rescan_k%0d", k));
    end
    mode_a = 1'b0; sel_a = 2'd3;
    tick_exp(0, {10'b0, exp_a[2]}, 1'b1, 3'd2, 1'b0, "scan_exit_edge");
    tick_exp(0, {10'b0, exp_a[3]}, 1'b1, 3'd3, 1'b0, "back_to_manual");

    // 6: wide instance
    en_n_b = 3'b000;
    sel_b = 3'd7; tick_exp(1, 12'h0, 1'b0, 3'd7, 1'b0, "b_sel7_oor");
    sel_b = 3'd5; tick_exp(1, 12'h0, 1'b0, 3'd5, 1'b0, "b_sel5_oor");
    sel_b = 3'd4; tick_exp(1, exp_b[4], 1'b1, 3'd4, 1'b0, "b_sel4");
    en_n_b = 3'b010; tick_exp(1, 12'hA05, 1'b1, 3'd4, 1'b0, "b_ch1_off");
    en_n_b = 3'b000; sel_b = 3'd0; mode_b = 1'b1;
    tick_exp(1, exp_b[0], 1'b1, 3'd0, 1'b0, "b_scan_entry");
    for (int k = 1; k <= 12; k++) begin
      s = ((k - 1) / 2) % 5;
      tick_exp(1, exp_b[s], 1'b1, 3'(s), k == 10, $sformatf("b_scan_k%0d", k));
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1 check("scoreboard_drained", 17'(sb.size()), 17'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
